// File: rtl/lstm_addr_seq_if.sv
// Bus bundle for the LSTM operand address sequencer: pass control in,
// address/index stream and status out.
interface lstm_addr_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             dir;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] addr;
   logic [WIDTH-1:0] word_idx;
   logic [WIDTH-1:0] step_idx;
   logic             valid;
   logic             last_word;
   logic             busy;
   logic             done;

   modport master (
      output start, dir, en, abort,
      input  addr, word_idx, step_idx, valid, last_word, busy, done
   );

   modport slave (
      input  start, dir, en, abort,
      output addr, word_idx, step_idx, valid, last_word, busy, done
   );
endinterface

// File: rtl/lstm_addr_seq.sv
// LSTM operand address sequencer. Walks a block of NUM words per timestep
// over NUM_ITERATIONS timesteps, forward or reverse (BPTT), starting at BASE.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; outputs invalid
//   RUN   | presenting one address per enabled cycle
//   DONE  | one-cycle completion pulse; indices hold their final values
module lstm_addr_seq #(
   parameter int               WIDTH          = 32,
   parameter int               NUM            = 3,
   parameter int               NUM_ITERATIONS = 5,
   parameter logic [WIDTH-1:0] BASE           = '0
) (
   input logic            clk,
   input logic            rst,
   lstm_addr_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] WORD_LAST = WIDTH'(NUM - 1);
   localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'(NUM_ITERATIONS - 1);
   localparam logic [WIDTH-1:0] ADDR_LAST = BASE + WIDTH'(NUM * NUM_ITERATIONS - 1);

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] step_q, step_d;

   logic at_final;
   logic word_end;

   // Final address of the pass and last word of a timestep, both in the
   // latched direction.
   always_comb begin
      if (dir_q) begin
         word_end = (word_q == '0);
         at_final = (word_q == '0) && (step_q == '0);
      end else begin
         word_end = (word_q == WORD_LAST);
         at_final = (word_q == WORD_LAST) && (step_q == STEP_LAST);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         addr_q  <= '0;
         word_q  <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         step_q  <= step_d;
      end
   end

   // Next state and next indices. Since addr = BASE + step*NUM + word, a
   // one-word advance always moves the address by exactly one, so the
   // address tracks the indices with an incrementer instead of a multiplier.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      addr_d  = addr_q;
      word_d  = word_q;
      step_d  = step_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = RUN;
               dir_d   = bus.dir;
               if (bus.dir) begin
                  addr_d = ADDR_LAST;
                  word_d = WORD_LAST;
                  step_d = STEP_LAST;
               end else begin
                  addr_d = BASE;
                  word_d = '0;
                  step_d = '0;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               addr_d  = '0;
               word_d  = '0;
               step_d  = '0;
            end else if (bus.en) begin
               if (at_final) begin
                  state_d = DONE;
               end else if (dir_q) begin
                  addr_d = addr_q - 1'b1;
                  if (word_end) begin
                     word_d = WORD_LAST;
                     step_d = step_q - 1'b1;
                  end else begin
                     word_d = word_q - 1'b1;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
                  if (word_end) begin
                     word_d = '0;
                     step_d = step_q + 1'b1;
                  end else begin
                     word_d = word_q + 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (bus.abort) begin
               addr_d = '0;
               word_d = '0;
               step_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.addr      = addr_q;
   assign bus.word_idx  = word_q;
   assign bus.step_idx  = step_q;
   assign bus.valid     = (state_q == RUN);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.last_word = (state_q == RUN) && word_end;

endmodule

// File: tb/tb_lstm_addr_seq.sv
// Bench for lstm_addr_seq: two instances (3x2 and 1x1, BASE=0x10) driven by
// the same control inputs and compared every cycle against a pass-position
// reference model, plus directed pass scenarios with fixed expected streams.
module tb_lstm_addr_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lstm_addr_seq_if #(.WIDTH(32)) if0 ();
   lstm_addr_seq_if #(.WIDTH(32)) if1 ();

   lstm_addr_seq #(.WIDTH(32), .NUM(3), .NUM_ITERATIONS(2), .BASE(32'h10)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   lstm_addr_seq #(.WIDTH(32), .NUM(1), .NUM_ITERATIONS(1), .BASE(32'h10)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   logic [31:0] o_addr[2], o_word[2], o_step[2];
   logic        o_valid[2], o_last[2], o_busy[2], o_done[2];
   assign o_addr[0] = if0.addr;      assign o_addr[1] = if1.addr;
   assign o_word[0] = if0.word_idx;  assign o_word[1] = if1.word_idx;
   assign o_step[0] = if0.step_idx;  assign o_step[1] = if1.step_idx;
   assign o_valid[0] = if0.valid;    assign o_valid[1] = if1.valid;
   assign o_last[0] = if0.last_word; assign o_last[1] = if1.last_word;
   assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;
   assign o_done[0] = if0.done;      assign o_done[1] = if1.done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode 0=idle 1=run 2=done, k = position in pass order
   int nums[2] = '{3, 1};
   int its[2]  = '{2, 1};
   int m_mode[2], m_k[2], m_dir[2], m_clr[2];

   // capture of instance 0 for directed scenarios
   logic [31:0] cap_addr[$], cap_step[$], cap_last[$];
   int done_cnt, done_cyc, cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_mode[d] = 0; m_k[d] = 0; m_dir[d] = 0; m_clr[d] = 1;
      end
   endtask

   task automatic model_update(input logic s, input logic dr, input logic e, input logic a);
      for (int d = 0; d < 2; d++) begin
         int total;
         total = nums[d] * its[d];
         case (m_mode[d])
            0: if (s && !a) begin
                  m_mode[d] = 1; m_dir[d] = int'(dr); m_k[d] = 0; m_clr[d] = 0;
               end
            1: if (a) begin
                  m_mode[d] = 0; m_clr[d] = 1;
               end else if (e) begin
                  if (m_k[d] == total - 1) m_mode[d] = 2;
                  else m_k[d] = m_k[d] + 1;
               end
            default: begin
               m_mode[d] = 0;
               if (a) m_clr[d] = 1;
            end
         endcase
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         int total, pos, ew, es;
         logic el;
         total = nums[d] * its[d];
         pos = (m_dir[d] != 0) ? (total - 1 - m_k[d]) : m_k[d];
         ew = pos % nums[d];
         es = pos / nums[d];
         el = (m_mode[d] == 1) && ((m_dir[d] != 0) ? (ew == 0) : (ew == nums[d] - 1));
         chk($sformatf("d%0d_valid", d), 32'(o_valid[d]), 32'(m_mode[d] == 1));
         chk($sformatf("d%0d_busy", d),  32'(o_busy[d]),  32'(m_mode[d] != 0));
         chk($sformatf("d%0d_done", d),  32'(o_done[d]),  32'(m_mode[d] == 2));
         chk($sformatf("d%0d_last", d),  32'(o_last[d]),  32'(el));
         if (m_clr[d] != 0) begin
            chk($sformatf("d%0d_addr_clr", d), o_addr[d], 32'h0);
            chk($sformatf("d%0d_word_clr", d), o_word[d], 32'h0);
            chk($sformatf("d%0d_step_clr", d), o_step[d], 32'h0);
         end else if (m_mode[d] != 0) begin
            chk($sformatf("d%0d_addr", d), o_addr[d], 32'h10 + 32'(pos));
            chk($sformatf("d%0d_word", d), o_word[d], 32'(ew));
            chk($sformatf("d%0d_step", d), o_step[d], 32'(es));
         end
      end
   endtask

   task automatic drive(input logic s, input logic dr, input logic e, input logic a);
      if0.start = s; if0.dir = dr; if0.en = e; if0.abort = a;
      if1.start = s; if1.dir = dr; if1.en = e; if1.abort = a;
   endtask

   // one clock: drive, check at negedge, clock the model at posedge
   task automatic step(input logic s, input logic dr, input logic e, input logic a);
      drive(s, dr, e, a);
      @(negedge clk);
      check_outputs();
      if (o_valid[0]) begin
         cap_addr.push_back(o_addr[0]);
         cap_step.push_back(o_step[0]);
         if (o_last[0]) cap_last.push_back(o_addr[0]);
      end
      if (o_done[0]) begin
         done_cnt++;
         done_cyc = cyc;
      end
      cyc++;
      @(posedge clk);
      model_update(s, dr, e, a);
      #1;
   endtask

   task automatic cap_clear();
      cap_addr.delete(); cap_step.delete(); cap_last.delete();
      done_cnt = 0; done_cyc = -1; cyc = 0;
   endtask

   // asynchronous reset between clock edges; outputs must clear at once
   task automatic async_reset();
      drive(0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_valid", d), 32'(o_valid[d]), 32'h0);
         chk($sformatf("d%0d_rst_busy", d),  32'(o_busy[d]),  32'h0);
         chk($sformatf("d%0d_rst_done", d),  32'(o_done[d]),  32'h0);
         chk($sformatf("d%0d_rst_last", d),  32'(o_last[d]),  32'h0);
         chk($sformatf("d%0d_rst_addr", d),  o_addr[d], 32'h0);
         chk($sformatf("d%0d_rst_word", d),  o_word[d], 32'h0);
         chk($sformatf("d%0d_rst_step", d),  o_step[d], 32'h0);
      end
      model_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_queue(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
      chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
   endtask

   initial begin
      logic [31:0] exp_q[$];
      rst = 1'b0;
      drive(0, 0, 0, 0);
      model_reset();
      cap_clear();
      #12;
      check_outputs();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // forward pass, en always high
      cap_clear();
      step(1, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
      chk_queue("fwd_addr", cap_addr, exp_q);
      exp_q = '{32'h12, 32'h15};
      chk_queue("fwd_last", cap_last, exp_q);
      chk("fwd_done_cnt", 32'(done_cnt), 32'd1);
      chk("fwd_done_cyc", 32'(done_cyc), 32'd7);
      chk("fwd_busy_after", 32'(o_busy[0]), 32'h0);

      // reverse pass
      cap_clear();
      step(1, 1, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      exp_q = '{32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10};
      chk_queue("rev_addr", cap_addr, exp_q);
      exp_q = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
      chk_queue("rev_step", cap_step, exp_q);
      exp_q = '{32'h13, 32'h10};
      chk_queue("rev_last", cap_last, exp_q);
      chk("rev_done_cnt", 32'(done_cnt), 32'd1);

      // forward with a two-cycle stall at 0x13
      cap_clear();
      step(1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h13, 32'h14, 32'h15};
      chk_queue("stall_addr", cap_addr, exp_q);
      chk("stall_done_cyc", 32'(done_cyc), 32'd9);

      // start while busy ignored, abort at 0x12
      cap_clear();
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      step(1, 1, 1, 0);
      step(0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      exp_q = '{32'h10, 32'h11, 32'h12};
      chk_queue("abort_addr", cap_addr, exp_q);
      chk("abort_done_cnt", 32'(done_cnt), 32'd0);

      // start and abort together in idle: start dropped
      step(1, 0, 1, 1);
      step(0, 0, 1, 0);
      chk("start_abort_idle", 32'(o_busy[0]), 32'h0);

      // asynchronous reset mid-pass at 0x14, then a fresh pass
      cap_clear();
      step(1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      chk("pre_rst_addr", o_addr[0], 32'h14);
      async_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      cap_clear();
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("rst_restart_first", cap_addr.size() > 0 ? cap_addr[0] : 32'hffff_ffff, 32'h10);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);

      // randomized control traffic
      for (int i = 0; i < 1500; i++) begin
         logic s, dr, e, a;
         s  = ($urandom_range(3) == 0);
         dr = 1'($urandom_range(1));
         e  = ($urandom_range(3) != 0);
         a  = ($urandom_range(15) == 0);
         if ($urandom_range(199) == 0) async_reset();
         else step(s, dr, e, a);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lstm_addr_seq.md
LSTM_ADDR_SEQ -- requirements
Module: lstm_addr_seq

Interface
REQ-001 Parameter WIDTH, default 32, width of the address and index outputs.
REQ-002 Parameter NUM, default 3, words per timestep (≥1).
REQ-003 Parameter NUM_ITERATIONS, default 5, timesteps per pass (≥1).
REQ-004 Parameter BASE, default 0, first memory address of the operand block.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 Port start  input  1  request a pass; accepted only in IDLE.
REQ-008 Port dir  input  1  pass direction, sampled on accepted start: 0 = forward, 1 = reverse (BPTT).
REQ-009 Port en  input  1  advance enable; 0 stalls the sequence in RUN.
REQ-010 Port abort  input  1  synchronous cancel of a pass in progress.
REQ-011 Port addr  output  WIDTH  current memory address.
REQ-012 Port word_idx  output  WIDTH  word index within the current timestep, 0..NUM-1.
REQ-013 Port step_idx  output  WIDTH  timestep index, 0..NUM_ITERATIONS-1.
REQ-014 Port valid  output  1  addr/word_idx/step_idx are meaningful.
REQ-015 Port last_word  output  1  valid and word_idx is the final word of the timestep in the pass direction.
REQ-016 Port busy  output  1  state is not IDLE.
REQ-017 Port done  output  1  one-cycle pulse at pass completion.

Function
REQ-018 States: IDLE, RUN, DONE; the state is held in a registered state variable.
REQ-019 IDLE: valid=0, done=0; start=1 moves to RUN on the next edge and latches dir.
REQ-020 First RUN cycle, forward: word_idx=0, step_idx=0, addr=BASE.
REQ-021 First RUN cycle, reverse: word_idx=NUM-1, step_idx=NUM_ITERATIONS-1, addr=BASE+NUM*NUM_ITERATIONS-1.
REQ-022 In RUN, valid=1 and addr=BASE+step_idx*NUM+word_idx at all times; the product is computed modulo 2^WIDTH.
REQ-023 In RUN with en=1, forward: word_idx increments; at NUM-1 it wraps to 0 and step_idx increments.
REQ-024 In RUN with en=1, reverse: word_idx decrements; at 0 it wraps to NUM-1 and step_idx decrements.
REQ-025 In RUN with en=0: all outputs hold their values; no advance.
REQ-026 In RUN with en=1 on the final address (forward: step NUM_ITERATIONS-1/word NUM-1; reverse: step 0/word 0): next state is DONE.
REQ-027 DONE lasts exactly one cycle: done=1, valid=0, busy=1, indices hold their final values; then IDLE.
REQ-028 A pass takes NUM*NUM_ITERATIONS valid cycles with en held high; done is asserted on the cycle after the final address.
REQ-029 start while busy=1 is ignored; start and dir are not queued.
REQ-030 abort=1 in RUN or DONE: next state IDLE, valid=0, no done pulse, indices cleared to 0; abort has priority over en and start.
REQ-031 abort=1 in IDLE has no effect; when start=1 and abort=1 together in IDLE, abort takes priority and start is dropped.
REQ-032 NUM=1 and/or NUM_ITERATIONS=1 are legal; for NUM=NUM_ITERATIONS=1 the single address is BASE, and last_word=1 on it.
REQ-033 All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-034 rst=0 forces immediately, regardless of clk: state IDLE, addr=0, word_idx=0, step_idx=0, valid=0, last_word=0, busy=0, done=0, latched dir=0.
REQ-035 Reset in the middle of a pass discards the pass; no done pulse follows; a new start after rst=1 begins a fresh pass.

Verification (NUM=3, NUM_ITERATIONS=2, BASE=0x10)
REQ-036 Forward, en=1 always: addr 0x10,11,12,13,14,15; last_word on 0x12 and 0x15; done on cycle 7 after start; then busy=0.
REQ-037 Reverse: addr 0x15,14,13,12,11,10; step_idx 1,1,1,0,0,0; last_word on 0x13 and 0x10; done once.
REQ-038 Forward with en=0 for 2 cycles at addr 0x13: 0x13 held 3 cycles; done delayed by 2 cycles.
REQ-039 abort at addr 0x12: next cycle IDLE, valid=0, no done; start during the pass at addr 0x11 is ignored.
REQ-040 rst=0 asserted asynchronously mid-pass at addr 0x14: all outputs go to 0 before the next clk edge; after release, start yields 0x10 first.
REQ-041 NUM=1, NUM_ITERATIONS=1: start gives one valid cycle, addr=0x10 with last_word=1, then done=1.
